// File: rtl/sparse_operand_loader.sv
// Host-side loader for the sparse polynomial multiplier: per-channel position RAMs plus a dense
// operand RAM behind one key/data request port, with per-entry valid tracking and a loaded flag.
`timescale 1ns/1ps
module sparse_operand_loader #(
  parameter int unsigned WEIGHT      = 66,
  parameter int unsigned POS_WIDTH   = 16,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DENSE_WORDS = 553,
  parameter int unsigned DENSE_WIDTH = 32,
  parameter int unsigned KEY_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_err_o,
  output logic                  loaded_o
);

  localparam int unsigned POS_STRIDE = 1 << $clog2(WEIGHT);
  localparam int unsigned DENSE_BASE = CHANNELS * POS_STRIDE;
  localparam int unsigned STATUS_KEY = (1 << KEY_WIDTH) - 1;
  localparam int unsigned PIDX_W     = $clog2(POS_STRIDE);
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DIDX_W     = $clog2(DENSE_WORDS);
  localparam int unsigned PCNT_W     = $clog2(WEIGHT + 1);
  localparam int unsigned DCNT_W     = $clog2(DENSE_WORDS + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, RESP} state_t;

  state_t state_q, state_d;

  logic                hit_pos, hit_dense, hit_status, acc, wr_acc;
  logic [CH_W-1:0]     ch, ch_q;
  logic [PIDX_W-1:0]   pidx, pidx_q, pos_addr;
  logic [DIDX_W-1:0]   didx, didx_q, dense_addr;
  logic                is_dense_q;

  logic [WEIGHT-1:0]      pos_vld_q [CHANNELS];
  logic [WEIGHT-1:0]      pos_vld_d [CHANNELS];
  logic [PCNT_W-1:0]      pos_cnt_q [CHANNELS];
  logic [PCNT_W-1:0]      pos_cnt_d [CHANNELS];
  logic [DENSE_WORDS-1:0] dense_vld_q, dense_vld_d;
  logic [DCNT_W-1:0]      dense_cnt_q, dense_cnt_d;
  logic                   loaded_d;

  logic [POS_WIDTH-1:0]   pos_rdata [CHANNELS];
  logic [DENSE_WIDTH-1:0] dense_rdata;
  logic [DATA_WIDTH-1:0]  status_data, rd_word;
  logic                   rd_hit;
  logic                   unused_bits;

  // Key decode: position windows are power-of-two aligned, dense words follow them.
  always_comb begin
    ch         = CH_W'(key_i >> PIDX_W);
    pidx       = PIDX_W'(key_i);
    didx       = DIDX_W'(key_i - KEY_WIDTH'(DENSE_BASE));
    hit_pos    = (32'(key_i) < DENSE_BASE) && (32'(pidx) < WEIGHT);
    hit_dense  = (32'(key_i) >= DENSE_BASE) && (32'(key_i) < DENSE_BASE + DENSE_WORDS);
    hit_status = (32'(key_i) == STATUS_KEY);
  end

  assign acc         = (state_q == IDLE) && req_ready_o && req_valid_i;
  assign wr_acc      = acc && req_write_i;
  assign unused_bits = ^data_i[DATA_WIDTH-1:DENSE_WIDTH];

  // Single RAM port: request key while idle, latched key while a read is in flight.
  assign pos_addr   = (state_q == IDLE) ? pidx : pidx_q;
  assign dense_addr = (state_q == IDLE) ? didx : didx_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_pos_ram
    logic [POS_WIDTH-1:0] mem [WEIGHT];
    logic [POS_WIDTH-1:0] q;
    always_ff @(posedge clk) begin
      if (wr_acc && hit_pos && (ch == CH_W'(c))) mem[pos_addr] <= data_i[POS_WIDTH-1:0];
      q <= mem[pos_addr];
    end
    assign pos_rdata[c] = q;
  end

  logic [DENSE_WIDTH-1:0] dense_mem [DENSE_WORDS];
  always_ff @(posedge clk) begin
    if (wr_acc && hit_dense) dense_mem[dense_addr] <= data_i[DENSE_WIDTH-1:0];
    dense_rdata <= dense_mem[dense_addr];
  end

  // Bitmap/counter next state; loaded is derived from the next counts so it tracks writes at T+1.
  always_comb begin
    pos_vld_d   = pos_vld_q;
    pos_cnt_d   = pos_cnt_q;
    dense_vld_d = dense_vld_q;
    dense_cnt_d = dense_cnt_q;
    if (wr_acc) begin
      if (hit_status && data_i[0]) begin
        for (int c = 0; c < CHANNELS; c++) begin
          pos_vld_d[c] = '0;
          pos_cnt_d[c] = '0;
        end
        dense_vld_d = '0;
        dense_cnt_d = '0;
      end else if (hit_pos && !pos_vld_q[ch][pidx]) begin
        pos_vld_d[ch][pidx] = 1'b1;
        pos_cnt_d[ch]       = pos_cnt_q[ch] + PCNT_W'(1);
      end else if (hit_dense && !dense_vld_q[didx]) begin
        dense_vld_d[didx] = 1'b1;
        dense_cnt_d       = dense_cnt_q + DCNT_W'(1);
      end
    end
    loaded_d = (dense_cnt_d == DCNT_W'(DENSE_WORDS));
    for (int c = 0; c < CHANNELS; c++) begin
      if (pos_cnt_d[c] != PCNT_W'(WEIGHT)) loaded_d = 1'b0;
    end
  end

  always_comb begin
    status_data        = '0;
    status_data[0]     = loaded_o;
    status_data[31:16] = 16'(dense_cnt_q);
    for (int c = 0; c < CHANNELS; c++) begin
      status_data[32 + 16*c +: 16] = 16'(pos_cnt_q[c]);
    end
  end

  always_comb begin
    rd_hit  = is_dense_q ? dense_vld_q[didx_q] : pos_vld_q[ch_q][pidx_q];
    rd_word = is_dense_q ? DATA_WIDTH'(dense_rdata) : DATA_WIDTH'(pos_rdata[ch_q]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = (!req_write_i && (hit_pos || hit_dense)) ? RD_WAIT : RESP;
      RD_WAIT: state_d = RD_DATA;
      RD_DATA: state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_err_o   <= 1'b0;
      loaded_o     <= 1'b0;
      pos_vld_q    <= '{default: '0};
      pos_cnt_q    <= '{default: '0};
      dense_vld_q  <= '0;
      dense_cnt_q  <= '0;
      ch_q         <= '0;
      pidx_q       <= '0;
      didx_q       <= '0;
      is_dense_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_o  <= (state_d == IDLE);
      resp_valid_o <= (state_d == RESP);
      loaded_o     <= loaded_d;
      pos_vld_q    <= pos_vld_d;
      pos_cnt_q    <= pos_cnt_d;
      dense_vld_q  <= dense_vld_d;
      dense_cnt_q  <= dense_cnt_d;
      if (acc) begin
        ch_q        <= ch;
        pidx_q      <= pidx;
        didx_q      <= didx;
        is_dense_q  <= hit_dense;
        resp_err_o  <= !(hit_pos || hit_dense || hit_status);
        resp_data_o <= (!req_write_i && hit_status) ? status_data : '0;
      end else if (state_q == RD_WAIT) begin
        resp_data_o <= rd_hit ? rd_word : '0;
      end
    end
  end

endmodule

// File: doc/sparse_operand_loader.md
# sparse_operand_loader

Parametrised host-side loader for the sparse polynomial multiplier. It writes and reads back the sparse position lists for several channels and the dense random-bit operand through a single key/data request port with valid/ready handshakes. It tracks which entries have been written and raises `loaded_o` when every operand word is present. It sits between the CW305 register bridge and the multiplier core.

## Interface
- `WEIGHT`, 66: positions per channel.
- `POS_WIDTH`, 16: bits per position entry.
- `CHANNELS`, 2: number of position lists (1–6).
- `DENSE_WORDS`, 553: dense operand depth in words.
- `DENSE_WIDTH`, 32: dense word width.
- `KEY_WIDTH`, 12: key bus width.
- `DATA_WIDTH`, 128: request/response data width.
- `POS_STRIDE`, 2^clog2(`WEIGHT`): key window per channel.
- `DENSE_BASE`, `CHANNELS`*`POS_STRIDE`: first dense key.
- `STATUS_KEY`, 2^`KEY_WIDTH`-1: status/control key.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: loader accepts a request this cycle.
- `req_write_i` in 1: 1 = write, 0 = read.
- `key_i` in `KEY_WIDTH`: target key.
- `data_i` in `DATA_WIDTH`: write data; low bits are used.
- `resp_valid_o` out 1: response present.
- `resp_ready_i` in 1: host consumes the response.
- `resp_data_o` out `DATA_WIDTH`: read data. Always 0 for write responses.
- `resp_err_o` out 1: the key was out of range.
- `loaded_o` out 1: all position and dense entries have been written since the last clear.

## Operation
- Key decode:
  - Keys c*`POS_STRIDE`+i, with c<`CHANNELS` and i<`WEIGHT`, select position RAM c, entry i.
  - Keys `DENSE_BASE`+j, with j<`DENSE_WORDS`, select dense word j.
  - `STATUS_KEY` selects the status/control register.
  - Every other key is out of range. A write to it changes nothing. Both reads and writes to it respond with `resp_err_o`=1 and data 0.
- Storage:
  - One single-port synchronous RAM per channel (`POS_WIDTH`×`WEIGHT`).
  - One dense RAM (`DENSE_WIDTH`×`DENSE_WORDS`).
  - Read latency is 1 cycle from the registered address.
- Writes store `data_i[POS_WIDTH-1:0]` or `data_i[DENSE_WIDTH-1:0]`. Writing a value of zero is a legal write.
- Valid bitmaps:
  - Each entry has a valid bit.
  - The first write to an entry sets its bit and increments that region's counter: `pos_count[c]` or `dense_count`.
  - Rewrites update the data only. The counter does not change.
  - A read of an entry whose valid bit is 0 returns 0, whatever the RAM contains.
- `loaded_o` = (every `pos_count[c]` == `WEIGHT`) AND (`dense_count` == `DENSE_WORDS`). It is registered.
- Status read data:
  - [0] `loaded_o`.
  - [31:16] `dense_count`.
  - [32+16c +: 16] `pos_count[c]`.
  - All other bits 0.
- Status write:
  - If `data_i[0]`=1, clear all valid bits and counters. RAM contents are untouched.
  - If `data_i[0]`=0, no effect.
  - Either way the response is ok, with `resp_err_o`=0.
- FSM states: IDLE, RD_WAIT, RD_DATA, RESP.
  - IDLE: `req_ready_o`=1. An accepted write updates RAM and bitmaps in that cycle, then goes to RESP. An accepted memory read registers the address, then goes to RD_WAIT. An accepted status or out-of-range read goes to RESP with its data.
  - RD_WAIT → RD_DATA: capture RAM q, gated by the valid bit, into the response register.
  - RD_DATA → RESP.
  - RESP: `resp_valid_o`=1 and is held stable until `resp_ready_i`=1, then back to IDLE.
- Only one request is outstanding at a time. `req_ready_o`=0 in every state except IDLE.

## Timing
- Reset (async assert, sync deassert use):
  - FSM goes to IDLE.
  - `req_ready_o`, `resp_valid_o`, `resp_err_o`, `loaded_o` = 0. `resp_data_o` = 0.
  - All bitmaps and counters = 0.
  - `req_ready_o` rises on the first clock edge after `rst_n` deasserts.
- Request acceptance happens at edge T, when `req_valid_i` & `req_ready_o` are both 1.
- Response latency:
  - Writes, status accesses and errors: `resp_valid_o` is high from T+1.
  - Memory reads: `resp_valid_o` is high from T+3.
- `req_ready_o` returns high the cycle after the response handshake. Peak throughput is one request per 2 cycles (writes) or 4 cycles (memory reads) with `resp_ready_i` tied high.
- After a write or clear, `loaded_o` reflects the new counts at T+1.
- A clear that coincides with `loaded_o`=1 drops `loaded_o` at T+1.
- Reset mid-transaction aborts it with no response. Partially accepted writes are lost only if reset precedes edge T.
- Response backpressure: `resp_data_o` and `resp_err_o` must not change while `resp_valid_o`=1 and `resp_ready_i`=0.

## Test plan
- Reset, then read key 0 → response at T+3: data 0, err 0 (unwritten entry). Status read → 0.
- Write key 5 = 0x1234, read key 5 → data 0x1234. Rewrite key 5 = 0x0000 → status [47:32] stays 1, and a read returns 0.
- Write all 2×66 positions and 553 dense words, using `CHANNELS`=2 and `DENSE_BASE`=256 → `loaded_o` rises 1 cycle after the final write. Status [31:16]=553, [47:32]=66, [63:48]=66.
- Write key 100 (gap in channel 0) and key 900 (beyond the dense range) → `resp_err_o`=1 for both, counters unchanged. Read of either returns 0 with err 1.
- Hold `resp_ready_i`=0 for 10 cycles during a read response → `resp_valid_o` and `resp_data_o` stay stable, and `req_ready_o` stays 0 throughout.
- With `loaded_o`=1, write `STATUS_KEY` = 1 → `loaded_o`=0 at T+1, all counts 0, and a read of key 5 returns 0. Assert `rst_n` low mid-read → `resp_valid_o` drops immediately.
